// File: rtl/tmds_video_framer.sv
// N-channel TMDS 8b/10b encoder and video-period framer with a 10-stage lookahead delay line.
// Define HDMI_PREAMBLE_EN for HDMI preamble/guard insertion and ctl-driven control codes; undefined gives pure DVI.
module tmds_video_framer #(
  parameter int CHANNELS  = 3,
  parameter int LOOKAHEAD = 10
) (
  input  logic                   pxclk,
  input  logic                   rst,
  input  logic [8*CHANNELS-1:0]  pixel,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [3:0]             ctl,
  input  logic                   visible,
  output logic [10*CHANNELS-1:0] data,
  output logic                   out_de,
  output logic                   frame_err
);

  // state    | meaning
  // CTRL     | blanking, control codes on every channel
  // PREAMBLE | 8 cycles of HDMI video preamble
  // GUARD    | 2 cycles of video guard band
  // VIDEO    | 8b/10b encoded pixels
  typedef enum logic [1:0] {ST_CTRL, ST_PREAMBLE, ST_GUARD, ST_VIDEO} state_t;

  localparam logic [9:0] CODE_00 = 10'b1101010100;
  localparam logic [9:0] CODE_01 = 10'b0010101011;
  localparam logic [9:0] CODE_10 = 10'b0101010100;
  localparam logic [9:0] CODE_11 = 10'b1010101011;
  localparam logic [9:0] GB_0    = 10'b1011001100;
  localparam logic [9:0] GB_1    = 10'b0100110011;

  if (LOOKAHEAD != 10) begin : g_bad_lookahead
    $error("tmds_video_framer: LOOKAHEAD must be 10");
  end
  if (CHANNELS < 1 || CHANNELS > 3) begin : g_bad_channels
    $error("tmds_video_framer: CHANNELS must be 1..3");
  end

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CODE_00;
      2'b01:   return CODE_01;
      2'b10:   return CODE_10;
      default: return CODE_11;
    endcase
  endfunction

  // Returns {word[9:0], next running disparity[4:0]}.
  function automatic logic [14:0] tmds_enc(input logic [7:0] d, input logic signed [4:0] cnt);
    logic [8:0] qm;
    logic [9:0] w;
    int n1d, n1q, c, nc;
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += int'(d[i]);
    qm[0] = d[0];
    qm[8] = !(n1d > 4 || (n1d == 4 && !d[0]));
    for (int i = 1; i < 8; i++) qm[i] = qm[8] ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    c = int'(cnt);
    if (c == 0 || n1q == 4) begin
      w  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nc = qm[8] ? c + 2*n1q - 8 : c + 8 - 2*n1q;
    end else if ((c > 0 && n1q > 4) || (c < 0 && n1q < 4)) begin
      w  = {1'b1, qm[8], ~qm[7:0]};
      nc = c + (qm[8] ? 2 : 0) + 8 - 2*n1q;
    end else begin
      w  = {1'b0, qm[8], qm[7:0]};
      nc = c - (qm[8] ? 0 : 2) + 2*n1q - 8;
    end
    return {w, nc[4:0]};
  endfunction

  logic [8*CHANNELS-1:0]  pix_q [LOOKAHEAD];
  logic [8*CHANNELS-1:0]  pix_d [LOOKAHEAD];
  logic [LOOKAHEAD-1:0]   vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
  logic signed [4:0]      disp_q [CHANNELS];
  logic signed [4:0]      disp_d [CHANNELS];
  logic [10*CHANNELS-1:0] data_q, data_d;
  logic                   out_de_q, out_de_d;
  logic                   frame_err_q, frame_err_d;
  state_t                 state_d;
  logic                   v_d;
  logic [9:0]             sync_code, blank_code1, blank_code2;

  assign v_d = vis_q[LOOKAHEAD-1];

  always_comb begin : delay_line
    pix_d[0] = pixel;
    for (int i = 1; i < LOOKAHEAD; i++) pix_d[i] = pix_q[i-1];
    vis_d = {vis_q[LOOKAHEAD-2:0], visible};
    hs_d  = {hs_q[LOOKAHEAD-2:0], hsync};
    vs_d  = {vs_q[LOOKAHEAD-2:0], vsync};
  end

`ifdef HDMI_PREAMBLE_EN
  logic [3:0] ctl_q [LOOKAHEAD];
  logic [3:0] ctl_d [LOOKAHEAD];
  state_t     state_q;
  logic [2:0] pre_cnt_q, pre_cnt_d;
  logic [3:0] gap_q, gap_d;
  logic       rise;

  always_comb begin : fsm_next
    ctl_d[0] = ctl;
    for (int i = 1; i < LOOKAHEAD; i++) ctl_d[i] = ctl_q[i-1];
    rise        = visible & ~vis_q[0];
    // gap_q reaches 0 only once 10 blank samples have entered since the last active one
    gap_d       = visible ? 4'd10 : ((gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1);
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_PREAMBLE: begin
        if (pre_cnt_q == 3'd0) begin
          state_d   = ST_GUARD;
          pre_cnt_d = 3'd1;
        end else begin
          pre_cnt_d = pre_cnt_q - 3'd1;
        end
      end
      ST_GUARD: begin
        if (pre_cnt_q == 3'd0) state_d = ST_VIDEO;
        else                   pre_cnt_d = pre_cnt_q - 3'd1;
      end
      ST_VIDEO: if (!v_d) state_d = ST_CTRL;
      default: ;
    endcase
    if (rise) begin
      if (state_d == ST_CTRL && gap_q == 4'd0 && !v_d) begin
        state_d   = ST_PREAMBLE;
        pre_cnt_d = 3'd7;
      end else begin
        frame_err_d = 1'b1;
      end
    end
    if (v_d) state_d = ST_VIDEO;
    blank_code1 = ctrl_code(ctl_q[LOOKAHEAD-1][1:0]);
    blank_code2 = ctrl_code(ctl_q[LOOKAHEAD-1][3:2]);
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^ctl;

  always_comb begin : fsm_next
    state_d     = v_d ? ST_VIDEO : ST_CTRL;
    frame_err_d = 1'b0;
    blank_code1 = CODE_00;
    blank_code2 = CODE_00;
  end
`endif

  always_comb begin : encode
    logic [14:0] enc;
    logic [9:0]  word;
    sync_code = ctrl_code({vs_q[LOOKAHEAD-1], hs_q[LOOKAHEAD-1]});
    out_de_d  = v_d;
    data_d    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      enc       = tmds_enc(pix_q[LOOKAHEAD-1][8*c +: 8], disp_q[c]);
      disp_d[c] = '0;
      word      = CODE_00;
      case (state_d)
        ST_VIDEO: begin
          word      = enc[14:5];
          disp_d[c] = enc[4:0];
        end
        ST_PREAMBLE: word = (c == 0) ? sync_code : ((c == 1) ? CODE_01 : CODE_00);
        ST_GUARD:    word = (c == 1) ? GB_1 : GB_0;
        default:     word = (c == 0) ? sync_code : ((c == 1) ? blank_code1 : blank_code2);
      endcase
      data_d[10*c +: 10] = word;
    end
  end

  always_ff @(posedge pxclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LOOKAHEAD; i++) pix_q[i] <= '0;
      vis_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) disp_q[c] <= '0;
      data_q      <= {CHANNELS{CODE_00}};
      out_de_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef HDMI_PREAMBLE_EN
      for (int i = 0; i < LOOKAHEAD; i++) ctl_q[i] <= '0;
      state_q   <= ST_CTRL;
      pre_cnt_q <= '0;
      gap_q     <= '0;
`endif
    end else begin
      for (int i = 0; i < LOOKAHEAD; i++) pix_q[i] <= pix_d[i];
      vis_q <= vis_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      for (int c = 0; c < CHANNELS; c++) disp_q[c] <= disp_d[c];
      data_q      <= data_d;
      out_de_q    <= out_de_d;
      frame_err_q <= frame_err_d;
`ifdef HDMI_PREAMBLE_EN
      for (int i = 0; i < LOOKAHEAD; i++) ctl_q[i] <= ctl_d[i];
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      gap_q     <= gap_d;
`endif
    end
  end

  assign data      = data_q;
  assign out_de    = out_de_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tmds_video_framer.sv
// Randomised bench for tmds_video_framer: per-cycle comparison against a history-based framing
// model and an 8b/10b reference, plus directed latency, preamble, guard and short-blanking checks.
module tb_tmds_video_framer;
  localparam int CH   = 3;
  localparam int MAXN = 4096;
`ifdef HDMI_PREAMBLE_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif
  localparam logic [9:0] CODE_00 = 10'b1101010100;
  localparam logic [9:0] CODE_01 = 10'b0010101011;
  localparam logic [9:0] CODE_10 = 10'b0101010100;
  localparam logic [9:0] CODE_11 = 10'b1010101011;
  localparam logic [9:0] GB_0    = 10'b1011001100;
  localparam logic [9:0] GB_1    = 10'b0100110011;

  logic        pxclk = 1'b0;
  logic        rst   = 1'b0;
  logic [23:0] pixel = '0;
  logic        hsync = 1'b0, vsync = 1'b0, visible = 1'b0;
  logic [3:0]  ctl   = '0;
  logic [29:0] data;
  logic        out_de, frame_err;

  always #5 pxclk = ~pxclk;

  tmds_video_framer #(.CHANNELS(CH), .LOOKAHEAD(10)) dut (
    .pxclk(pxclk), .rst(rst), .pixel(pixel), .hsync(hsync), .vsync(vsync),
    .ctl(ctl), .visible(visible), .data(data), .out_de(out_de), .frame_err(frame_err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit          vis_h [MAXN];
  bit          hs_h  [MAXN];
  bit          vs_h  [MAXN];
  logic [3:0]  ctl_h [MAXN];
  logic [23:0] pix_h [MAXN];
  logic [29:0] got_data [MAXN+1];
  bit          got_de   [MAXN+1];
  int n = 0;
  int rd_m [CH];
  int dut_rd [CH];
  int rd_viol = 0;
  bit err_m = 1'b0;

  function automatic bit hv(input int i);
    return (i < 0) ? 1'b0 : vis_h[i];
  endfunction

  // A run start is honoured only when the ten preceding input samples were blank.
  function automatic bit accepted(input int r);
    if (!hv(r)) return 1'b0;
    for (int k = 1; k <= 10; k++) if (hv(r-k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_rise(input int r);
    return hv(r) && !hv(r-1);
  endfunction

  // 0 control, 1 preamble, 2 guard, 3 video, for the word driven after cycle k
  function automatic int mode_of(input int k);
    if (hv(k-10)) return 3;
    if (HDMI) begin
      for (int d = 0; d < 10; d++) if (accepted(k-d)) return (d < 8) ? 1 : 2;
    end
    return 0;
  endfunction

  function automatic logic [9:0] code10(input logic [1:0] c);
    case (c)
      2'b00:   return CODE_00;
      2'b01:   return CODE_01;
      2'b10:   return CODE_10;
      default: return CODE_11;
    endcase
  endfunction

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int rd);
    int ones_d, ones_q;
    logic [7:0] q;
    bit q8, use_xnor;
    ones_d   = $countones(d);
    use_xnor = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8     = !use_xnor;
    ones_q = $countones(q);
    if (rd == 0 || ones_q == 4) return {~q8, q8, q8 ? q : ~q};
    if ((rd > 0 && ones_q > 4) || (rd < 0 && ones_q < 4)) return {1'b1, q8, ~q};
    return {1'b0, q8, q};
  endfunction

  task automatic step(input bit v, input logic [23:0] p, input bit h, input bit vs, input logic [3:0] c);
    int s, m;
    logic [23:0] sp;
    logic [3:0]  sc;
    bit sh, svs;
    logic [9:0]  w;
    logic [29:0] ed;
    if (n >= MAXN - 1) begin
      $display("FAIL history_overflow got=%0d exp<%0d", n, MAXN - 1);
      $fatal(1, "history overflow");
    end
    visible = v; pixel = p; hsync = h; vsync = vs; ctl = c;
    vis_h[n] = v; pix_h[n] = p; hs_h[n] = h; vs_h[n] = vs; ctl_h[n] = c;
    @(posedge pxclk);
    #1;
    s   = n - 10;
    sp  = (s >= 0) ? pix_h[s] : '0;
    sh  = (s >= 0) ? hs_h[s]  : 1'b0;
    svs = (s >= 0) ? vs_h[s]  : 1'b0;
    sc  = (s >= 0) ? ctl_h[s] : '0;
    m   = mode_of(n);
    for (int ch = 0; ch < CH; ch++) begin
      if (m == 3) begin
        w = ref_enc(sp[8*ch +: 8], rd_m[ch]);
        rd_m[ch] += 2*$countones(w) - 10;
      end else begin
        rd_m[ch] = 0;
        if (m == 1)      w = (ch == 0) ? code10({svs, sh}) : ((ch == 1) ? CODE_01 : CODE_00);
        else if (m == 2) w = (ch == 1) ? GB_1 : GB_0;
        else if (ch == 0) w = code10({svs, sh});
        else              w = HDMI ? code10((ch == 1) ? sc[1:0] : sc[3:2]) : CODE_00;
      end
      ed[10*ch +: 10] = w;
    end
    if (HDMI && is_rise(n) && !accepted(n)) err_m = 1'b1;
    chk($sformatf("data@%0d", n), data, ed);
    chk($sformatf("de_err@%0d", n), {out_de, frame_err}, {(m == 3), err_m});
    got_data[n+1] = data;
    got_de[n+1]   = out_de;
    for (int ch = 0; ch < CH; ch++) begin
      if (out_de) begin
        dut_rd[ch] += 2*$countones(data[10*ch +: 10]) - 10;
        if (dut_rd[ch] < -16 || dut_rd[ch] > 15) rd_viol++;
      end else begin
        dut_rd[ch] = 0;
      end
    end
    n++;
  endtask

  task automatic do_reset();
    rst = 1'b0; visible = 1'b0; pixel = '0; hsync = 1'b1; vsync = 1'b0; ctl = '0;
    repeat (3) begin
      @(posedge pxclk);
      #1;
      chk("rst_data", data, {3{CODE_00}});
      chk("rst_de_err", {out_de, frame_err}, 2'b00);
    end
    rst = 1'b1;
    n = 0; err_m = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin rd_m[ch] = 0; dut_rd[ch] = 0; end
  endtask

  task automatic blank(input int k, input bit rnd_ctl);
    repeat (k) step(1'b0, 24'($urandom), 1'($urandom), 1'($urandom),
                    rnd_ctl ? 4'($urandom) : 4'h0);
  endtask

  task automatic run(input int k, input bit zero, input bit rnd_ctl);
    repeat (k) step(1'b1, zero ? 24'h0 : 24'($urandom), 1'($urandom), 1'($urandom),
                    rnd_ctl ? 4'($urandom) : 4'h0);
  endtask

  initial begin
    int t, cnt_pre, cnt_gb, cnt_de;

    do_reset();
    repeat (12) step(1'b0, 24'h0, 1'b1, 1'b0, 4'h0);
    chk("lat_ch0_before", got_data[10][9:0], CODE_00);
    chk("lat_ch0_after",  got_data[11][9:0], CODE_01);
    chk("lat_ch12",       got_data[11][29:10], {CODE_00, CODE_00});
    chk("lat_de",         got_de[11], 1'b0);

    blank(20, 1'b1);
    t = n;
    run(4, 1'b1, 1'b1);
    blank(15, 1'b1);
    for (int k = 1; k <= 8; k++) chk("pre_ch12", got_data[t+k][29:10], {CODE_00, HDMI ? CODE_01 : CODE_00});
    for (int k = 9; k <= 10; k++) chk("guard_ch1", got_data[t+k][19:10], HDMI ? GB_1 : CODE_00);
    chk("first_video", got_data[t+11], {3{10'h100}});
    chk("first_de", {got_de[t+10], got_de[t+11]}, 2'b01);

    blank(20, 1'b0);
    t = n;
    run(1, 1'b0, 1'b0);
    blank(15, 1'b0);
    cnt_pre = 0; cnt_gb = 0; cnt_de = 0;
    for (int k = 1; k <= 14; k++) begin
      if (got_data[t+k][19:10] == CODE_01) cnt_pre++;
      if (got_data[t+k][19:10] == GB_1)    cnt_gb++;
      if (got_de[t+k])                     cnt_de++;
    end
    chk("single_pre_cnt", cnt_pre, HDMI ? 8 : 0);
    chk("single_gb_cnt",  cnt_gb,  HDMI ? 2 : 0);
    chk("single_de_cnt",  cnt_de,  1);
    chk("single_de_pos",  got_de[t+11], 1'b1);
    chk("single_err",     frame_err, 1'b0);

    blank(15, 1'b0);
    run(3, 1'b0, 1'b0);
    blank(5, 1'b0);
    t = n;
    run(3, 1'b0, 1'b0);
    blank(15, 1'b0);
    chk("short_err", frame_err, HDMI);
    chk("short_no_guard", got_data[t+10][19:10], CODE_00);
    chk("short_video_de", got_de[t+11], 1'b1);

    blank(12, 1'b1);
    run(14, 1'b0, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_data", data, {3{CODE_00}});
    chk("async_rst_de_err", {out_de, frame_err}, 2'b00);
    do_reset();

    blank(12, 1'b1);
    run(1280, 1'b0, 1'b1);
    blank(14, 1'b1);

    repeat (25) begin
      blank($urandom_range(1, 14), 1'b1);
      run($urandom_range(1, 16), 1'b0, 1'b1);
    end
    blank(14, 1'b1);

    chk("disp_range_viol", rd_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
